controle_gravacao_tabuleiro: RTL and testbench
==============================================

Name: controle_gravacao_tabuleiro

Overview:
- Sequencer between the piece-placement FSM and the per-player board memory.
- On a validation request it bounds-checks the ship and reads every cell the ship would cover.
- If the cells are free and in bounds, it writes the ship into the board; otherwise it reports a conflict.
- Drives the `conflito` input of the placement FSM; owns the only write path into board memory during the placement phase.

Parameters:
- BOARD_BITS, 3, coordinate width; board is 2^BOARD_BITS x 2^BOARD_BITS (8x8).
- CELL_W, 3, board cell width; 0 = water, tipo+1 = occupied by ship of that tipo.
- MEM_LAT, 1, board memory read latency in cycles (1..3).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- valida  in  1  validation request; rising edge starts an operation
- X1  in  BOARD_BITS  start column
- Y1  in  BOARD_BITS  start row
- direcao  in  1  0 = horizontal (+X), 1 = vertical (+Y)
- tipo  in  3  ship type 0..4
- jogador  in  1  board select (player 0/1)
- conflito  out  1  result: 1 = rejected, 0 = written
- pronto  out  1  one-cycle pulse, operation finished
- ocupado  out  1  high while an operation is in progress
- mem_addr  out  2*BOARD_BITS+1  {jogador, Y, X}
- mem_re  out  1  read strobe
- mem_we  out  1  write strobe
- mem_wdata  out  CELL_W  write data
- mem_rdata  in  CELL_W  read data, valid MEM_LAT cycles after mem_re

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state IDLE; conflito=0, pronto=0, ocupado=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Cells already written are not rolled back.
- Ship length L from tipo: 0→1, 1→2, 2→3, 3→4, 4→5.
- Start condition: valida high while its registered previous value was low, in IDLE only.
  - X1, Y1, direcao, tipo and jogador are latched on that edge; later input changes are ignored.
  - valida edges while ocupado=1 are ignored.
- States:
  - IDLE → BOUNDS on a start.
  - BOUNDS, 1 cycle: compute end = start + L − 1 in BOARD_BITS+1 bits on the moving axis.
    - If end > 7 or tipo > 4: conflito=1 → DONE, with no memory access.
    - Otherwise cell index i=0 → READ.
  - READ, 1 cycle: mem_re=1, mem_addr = cell i.
  - WAIT: MEM_LAT cycles.
  - CHECK: sample mem_rdata.
    - If nonzero: conflito=1 → DONE.
    - Else if i = L−1: i=0 → WRITE.
    - Else: i++ → READ.
  - WRITE, L cycles: mem_we=1, mem_wdata = tipo+1, mem_addr = cell i (i++ each cycle), then conflito=0 → DONE.
  - DONE, 1 cycle: pronto=1, then → IDLE.
- Cell i: (X1+i, Y1) if direcao=0, else (X1, Y1+i).
- ocupado = 1 in every state except IDLE.
- conflito holds its value from DONE until the next start (cleared in BOUNDS).
- mem_re and mem_we are never asserted together.
- mem_addr holds its last value in IDLE.
- Latency, start edge to pronto:
  - Success: 1 + L·(2+MEM_LAT) + L + 1 cycles. L=5, MEM_LAT=1 → 22 cycles.
  - Occupied cell k found: 1 + (k+1)·(2+MEM_LAT) + 1 cycles.
  - Out of bounds: 2 cycles.
- Boundary: ship ending exactly at coordinate 7 is legal. X1=7 with L=1 is legal. X1=7 with L=2 horizontal is rejected.

Optional Feature:
- Macro LIMPA_TABULEIRO_EN.
- Defined:
  - Adds input port `limpa` (1 bit, level sampled in IDLE) and state CLEAR.
  - A limpa sampled in IDLE latches jogador and writes 0 to all 64 cells of that board, one per cycle, X fastest (addresses {j,0,0} to {j,7,7}).
  - ocupado=1 during CLEAR; 64 cycles followed by DONE with pronto=1 and conflito=0.
  - limpa has priority over a simultaneous valida edge; that valida edge is lost.
- Undefined: no `limpa` port and no CLEAR state. Boards are cleared externally.

Decomposition:
- Shared package `batalha_pkg`:
  - board/coordinate/cell widths.
  - tipo encodings (SUBMARINO=0 … PORTA_AVIOES=4).
  - ship-length function or table.
  - state enum.
  - WATER=0 cell constant.
- One natural sub-module: `gerador_celula`, combinational, (X1, Y1, direcao, i, jogador) → mem_addr.
- FSM, index counter and edge detector stay in the top module.

Test Plan:
- tipo=4, X1=0, Y1=0, direcao=0, empty board → pronto 22 cycles after edge; conflito=0; cells {0,0,0..4} hold 5, others 0.
- tipo=1, X1=7, Y1=2, direcao=0 → pronto 2 cycles after edge; conflito=1; mem_re and mem_we never asserted.
- Preload cell {1,3,2}=2; tipo=3, jogador=1, X1=2, Y1=0, direcao=1 → conflito=1 after 4th read (pronto at cycle 1+4·3+1=14); no writes.
- Assert reset during the 3rd WRITE cycle of tipo=2 → outputs return to reset values immediately; first 2 cells written, third not; next valida edge operates normally.
- Hold valida high across DONE and re-pulse valida while ocupado=1 → exactly one operation; second starts only after valida low→high in IDLE.
- LIMPA_TABULEIRO_EN: fill board 0, pulse limpa → 64 consecutive writes of 0, then pronto=1 and conflito=0; board 1 untouched.

Source files
------------

// File: rtl/batalha_pkg.sv
// rtl/batalha_pkg.sv - shared widths, ship types, length table and sequencer states
package batalha_pkg;

   localparam int BOARD_BITS = 3;
   localparam int CELL_W     = 3;
   localparam int ADDR_W     = 2 * BOARD_BITS + 1;

   localparam logic [CELL_W-1:0]   WATER   = '0;
   localparam logic [BOARD_BITS:0] COMP_UM = (BOARD_BITS + 1)'(1);
   localparam logic [BOARD_BITS:0] LIMITE  = {1'b0, {BOARD_BITS{1'b1}}};

   typedef enum logic [2:0] {
      SUBMARINO        = 3'd0,
      CONTRATORPEDEIRO = 3'd1,
      CRUZADOR         = 3'd2,
      ENCOURACADO      = 3'd3,
      PORTA_AVIOES     = 3'd4
   } tipo_t;

   typedef enum logic [2:0] {
      IDLE, BOUNDS, READ, WAIT, CHECK, WRITE, DONE
`ifdef LIMPA_TABULEIRO_EN
      , CLEAR
`endif
   } estado_t;

   // Undefined types return 1 so the datapath stays well formed; BOUNDS rejects them anyway.
   function automatic logic [BOARD_BITS:0] comprimento(input logic [2:0] t);
      case (t)
         SUBMARINO:        return (BOARD_BITS + 1)'(1);
         CONTRATORPEDEIRO: return (BOARD_BITS + 1)'(2);
         CRUZADOR:         return (BOARD_BITS + 1)'(3);
         ENCOURACADO:      return (BOARD_BITS + 1)'(4);
         PORTA_AVIOES:     return (BOARD_BITS + 1)'(5);
         default:          return (BOARD_BITS + 1)'(1);
      endcase
   endfunction

endpackage

// File: rtl/controle_gravacao_tabuleiro_if.sv
// rtl/controle_gravacao_tabuleiro_if.sv - board memory bus between the sequencer and board RAM
interface controle_gravacao_tabuleiro_if;
   import batalha_pkg::*;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [CELL_W-1:0] mem_wdata;
   logic [CELL_W-1:0] mem_rdata;

   modport master (
      output mem_addr, mem_re, mem_we, mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr, mem_re, mem_we, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/gerador_celula.sv
// rtl/gerador_celula.sv - board address of the i-th cell covered by a ship
module gerador_celula
   import batalha_pkg::*;
(
   input  logic [BOARD_BITS-1:0] x1,
   input  logic [BOARD_BITS-1:0] y1,
   input  logic                  direcao,
   input  logic [BOARD_BITS-1:0] i,
   input  logic                  jogador,
   output logic [ADDR_W-1:0]     addr
);
   logic [BOARD_BITS-1:0] x;
   logic [BOARD_BITS-1:0] y;

   always_comb begin
      x = x1;
      y = y1;
      if (direcao) y = y1 + i;
      else         x = x1 + i;
      addr = {jogador, y, x};
   end
endmodule

// File: rtl/controle_gravacao_tabuleiro.sv
// rtl/controle_gravacao_tabuleiro.sv - ship placement check/write sequencer
// Optional board clear (limpa port, CLEAR state) under LIMPA_TABULEIRO_EN.
module controle_gravacao_tabuleiro
   import batalha_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valida,
   input  logic [BOARD_BITS-1:0] X1,
   input  logic [BOARD_BITS-1:0] Y1,
   input  logic                  direcao,
   input  logic [2:0]            tipo,
   input  logic                  jogador,
`ifdef LIMPA_TABULEIRO_EN
   input  logic                  limpa,
`endif
   output logic                  conflito,
   output logic                  pronto,
   output logic                  ocupado,
   controle_gravacao_tabuleiro_if.master mem
);
   localparam logic [1:0] LAT_FIM = 2'(MEM_LAT - 1);

   estado_t               estado, estado_n;
   logic                  valida_q;
   logic [BOARD_BITS-1:0] x_q, y_q;
   logic                  dir_q, jog_q;
   logic [2:0]            tipo_q;
   logic [BOARD_BITS-1:0] idx, idx_n;
   logic [1:0]            lat_cnt, lat_n;
   logic                  conflito_q, conflito_n;
   logic [ADDR_W-1:0]     addr_q, addr_cel;
   logic                  latch_op, latch_jog;
   logic                  inicio;
   logic [BOARD_BITS:0]   ultimo, fim;
   logic                  fora;
`ifdef LIMPA_TABULEIRO_EN
   logic [2*BOARD_BITS-1:0] clr_cnt, clr_n;
`endif

   assign inicio = valida && !valida_q && (estado == IDLE);
   assign ultimo = comprimento(tipo_q) - COMP_UM;
   assign fim    = {1'b0, (dir_q ? y_q : x_q)} + ultimo;
   assign fora   = (fim > LIMITE) || (tipo_q > 3'd4);

   gerador_celula u_gerador (
      .x1      (x_q),
      .y1      (y_q),
      .direcao (dir_q),
      .i       (idx),
      .jogador (jog_q),
      .addr    (addr_cel)
   );

   always_comb begin
      estado_n   = estado;
      idx_n      = idx;
      lat_n      = lat_cnt;
      conflito_n = conflito_q;
      latch_op   = 1'b0;
      latch_jog  = 1'b0;
`ifdef LIMPA_TABULEIRO_EN
      clr_n      = clr_cnt;
`endif
      case (estado)
         IDLE: begin
`ifdef LIMPA_TABULEIRO_EN
            // A clear request wins; the concurrent valida edge is consumed by valida_q.
            if (limpa) begin
               latch_jog = 1'b1;
               clr_n     = '0;
               estado_n  = CLEAR;
            end else
`endif
            if (inicio) begin
               latch_op = 1'b1;
               estado_n = BOUNDS;
            end
         end
         BOUNDS: begin
            conflito_n = fora;
            idx_n      = '0;
            estado_n   = fora ? DONE : READ;
         end
         READ: begin
            lat_n    = '0;
            estado_n = WAIT;
         end
         WAIT: begin
            if (lat_cnt == LAT_FIM) estado_n = CHECK;
            else                    lat_n    = lat_cnt + 2'd1;
         end
         CHECK: begin
            if (mem.mem_rdata != WATER) begin
               conflito_n = 1'b1;
               estado_n   = DONE;
            end else if ({1'b0, idx} == ultimo) begin
               idx_n    = '0;
               estado_n = WRITE;
            end else begin
               idx_n    = idx + 1'b1;
               estado_n = READ;
            end
         end
         WRITE: begin
            idx_n = idx + 1'b1;
            if ({1'b0, idx} == ultimo) begin
               conflito_n = 1'b0;
               estado_n   = DONE;
            end
         end
`ifdef LIMPA_TABULEIRO_EN
         CLEAR: begin
            clr_n = clr_cnt + 1'b1;
            if (clr_cnt == '1) begin
               conflito_n = 1'b0;
               estado_n   = DONE;
            end
         end
`endif
         DONE:    estado_n = IDLE;
         default: estado_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado     <= IDLE;
         valida_q   <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         dir_q      <= 1'b0;
         tipo_q     <= '0;
         jog_q      <= 1'b0;
         idx        <= '0;
         lat_cnt    <= '0;
         conflito_q <= 1'b0;
         addr_q     <= '0;
`ifdef LIMPA_TABULEIRO_EN
         clr_cnt    <= '0;
`endif
      end else begin
         estado     <= estado_n;
         valida_q   <= valida;
         idx        <= idx_n;
         lat_cnt    <= lat_n;
         conflito_q <= conflito_n;
`ifdef LIMPA_TABULEIRO_EN
         clr_cnt    <= clr_n;
`endif
         if (latch_op) begin
            x_q    <= X1;
            y_q    <= Y1;
            dir_q  <= direcao;
            tipo_q <= tipo;
         end
         if (latch_op || latch_jog) jog_q <= jogador;
         if (mem.mem_re || mem.mem_we) addr_q <= mem.mem_addr;
      end
   end

   always_comb begin
      mem.mem_re    = (estado == READ);
      mem.mem_we    = (estado == WRITE);
      mem.mem_wdata = WATER;
      mem.mem_addr  = addr_q;
      if (estado == READ || estado == WRITE) mem.mem_addr = addr_cel;
      if (estado == WRITE) mem.mem_wdata = CELL_W'(tipo_q) + CELL_W'(1);
`ifdef LIMPA_TABULEIRO_EN
      if (estado == CLEAR) begin
         mem.mem_we   = 1'b1;
         mem.mem_addr = {jog_q, clr_cnt};
      end
`endif
   end

   assign pronto   = (estado == DONE);
   assign ocupado  = (estado != IDLE);
   assign conflito = conflito_q;
endmodule

// File: tb/tb_controle_gravacao_tabuleiro.sv
// tb/tb_controle_gravacao_tabuleiro.sv - random and directed placement checks against a board model
module tb_controle_gravacao_tabuleiro;
   import batalha_pkg::*;

   localparam int ML = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       valida = 1'b0;
   logic [2:0] X1 = '0, Y1 = '0, tipo = '0;
   logic       direcao = 1'b0, jogador = 1'b0;
   logic       conflito, pronto, ocupado;
`ifdef LIMPA_TABULEIRO_EN
   logic       limpa = 1'b0;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   controle_gravacao_tabuleiro_if bus ();

   controle_gravacao_tabuleiro #(.MEM_LAT(ML)) dut (
      .clk      (clk),
      .reset    (reset),
      .valida   (valida),
      .X1       (X1),
      .Y1       (Y1),
      .direcao  (direcao),
      .tipo     (tipo),
      .jogador  (jogador),
`ifdef LIMPA_TABULEIRO_EN
      .limpa    (limpa),
`endif
      .conflito (conflito),
      .pronto   (pronto),
      .ocupado  (ocupado),
      .mem      (bus)
   );

   always #5 clk = ~clk;

   // board RAM with ML-cycle read latency; the last read value is held
   logic [CELL_W-1:0] board [128];
   logic [CELL_W-1:0] ref_b [128];
   logic              pre_we = 1'b0;
   logic [6:0]        pre_addr = '0;
   logic [CELL_W-1:0] pre_data = '0;
   logic [CELL_W-1:0] pd [ML];
   logic              pv [ML];
   logic [CELL_W-1:0] rd_q;

   assign bus.mem_rdata = pv[ML-1] ? pd[ML-1] : rd_q;

   always @(posedge clk) begin
      if (bus.mem_we)  board[bus.mem_addr] <= bus.mem_wdata;
      else if (pre_we) board[pre_addr] <= pre_data;
      pv[0] <= bus.mem_re;
      pd[0] <= board[bus.mem_addr];
      for (int i = 1; i < ML; i++) begin
         pv[i] <= pv[i-1];
         pd[i] <= pd[i-1];
      end
      rd_q <= bus.mem_rdata;
   end

   task automatic verifica(input string tag, input int obs, input int exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int celula(input int x, input int y, input int d, input int j, input int k);
      return j * 64 + (d != 0 ? (y + k) * 8 + x : y * 8 + x + k);
   endfunction

   // reference: outcome, latency, read/write counts; updates ref_b on success
   task automatic modelo(input int x, input int y, input int d, input int t, input int j,
                         output int conf, output int lat, output int nr, output int nw);
      int len;
      len = t + 1;
      conf = 0; nr = 0; nw = 0;
      if (t > 4 || (d != 0 ? y : x) + len - 1 > 7) begin
         conf = 1; lat = 2;
         return;
      end
      for (int k = 0; k < len; k++) begin
         nr++;
         if (ref_b[celula(x, y, d, j, k)] != 0) begin
            conf = 1;
            lat = 1 + (k + 1) * (2 + ML) + 1;
            return;
         end
      end
      for (int k = 0; k < len; k++) ref_b[celula(x, y, d, j, k)] = 3'(t + 1);
      nw = len;
      lat = 1 + len * (2 + ML) + len + 1;
   endtask

   task automatic preload(input int a, input int v);
      @(negedge clk);
      pre_addr = 7'(a); pre_data = 3'(v); pre_we = 1'b1;
      @(posedge clk); #1;
      pre_we = 1'b0;
      ref_b[a] = 3'(v);
   endtask

   task automatic operacao(input int x, input int y, input int d, input int t, input int j,
                           input bit agita);
      int conf, lat, nr, nw, n, reads, writes, sim, livre;
      modelo(x, y, d, t, j, conf, lat, nr, nw);
      @(negedge clk);
      X1 = 3'(x); Y1 = 3'(y); direcao = 1'(d); tipo = 3'(t); jogador = 1'(j); valida = 1'b1;
      n = 0; reads = 0; writes = 0; sim = 0; livre = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (bus.mem_re) reads++;
         if (bus.mem_we) writes++;
         if (bus.mem_re && bus.mem_we) sim++;
         if (!ocupado) livre++;
         if (!pronto && agita) begin
            X1 = 3'($urandom); Y1 = 3'($urandom); direcao = 1'($urandom);
            tipo = 3'($urandom); jogador = 1'($urandom); valida = 1'($urandom);
         end
      end while (!pronto && n < 200);
      verifica("latencia", n, lat);
      verifica("conflito", int'(conflito), conf);
      verifica("leituras", reads, nr);
      verifica("escritas", writes, nw);
      verifica("re_we_juntos", sim, 0);
      verifica("ocupado_op", livre, 0);
      valida = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         verifica("ocupado_idle", int'(ocupado), 0);
         verifica("conflito_mantido", int'(conflito), conf);
      end
      valida = 1'b0;
      @(posedge clk);
   endtask

   initial begin
      int n, w, ruim;
      for (int i = 0; i < 128; i++) ref_b[i] = '0;
      for (int i = 0; i < 128; i++) begin
         pre_addr = 7'(i); pre_data = '0; pre_we = 1'b1;
         @(posedge clk); #1;
      end
      pre_we = 1'b0;
      verifica("rst_conflito", int'(conflito), 0);
      verifica("rst_pronto", int'(pronto), 0);
      verifica("rst_ocupado", int'(ocupado), 0);
      verifica("rst_re", int'(bus.mem_re), 0);
      verifica("rst_we", int'(bus.mem_we), 0);
      verifica("rst_addr", int'(bus.mem_addr), 0);
      verifica("rst_wdata", int'(bus.mem_wdata), 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);

      operacao(0, 0, 0, 4, 0, 1'b0);
      operacao(7, 2, 0, 1, 0, 1'b0);
      preload(90, 2);
      operacao(2, 0, 1, 3, 1, 1'b0);

      // reset during the third write of a 3-cell ship at {1,5,0..2}
      @(negedge clk);
      X1 = 3'd0; Y1 = 3'd5; direcao = 1'b0; tipo = 3'd2; jogador = 1'b1; valida = 1'b1;
      n = 0; w = 0;
      while (w < 3 && n < 100) begin
         @(posedge clk); #1;
         n++;
         if (bus.mem_we) w++;
      end
      verifica("rst_meio_escritas", w, 3);
      reset = 1'b0;
      #1;
      verifica("rstm_we", int'(bus.mem_we), 0);
      verifica("rstm_re", int'(bus.mem_re), 0);
      verifica("rstm_addr", int'(bus.mem_addr), 0);
      verifica("rstm_wdata", int'(bus.mem_wdata), 0);
      verifica("rstm_ocupado", int'(ocupado), 0);
      verifica("rstm_pronto", int'(pronto), 0);
      verifica("rstm_conflito", int'(conflito), 0);
      ref_b[64 + 40] = 3'd3;
      ref_b[64 + 41] = 3'd3;
      @(negedge clk);
      valida = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);

      operacao(7, 3, 0, 0, 0, 1'b0);
      operacao(3, 4, 0, 4, 1, 1'b0);
      operacao(6, 4, 1, 3, 0, 1'b0);
      operacao(0, 5, 0, 2, 1, 1'b0);
      operacao(7, 6, 0, 1, 1, 1'b0);

      for (int r = 0; r < 40; r++)
         operacao($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1), 1'b1);

`ifdef LIMPA_TABULEIRO_EN
      @(negedge clk);
      jogador = 1'b0; limpa = 1'b1; valida = 1'b1;
      n = 0; w = 0; ruim = 0;
      do begin
         @(posedge clk); #1;
         limpa = 1'b0;
         n++;
         if (bus.mem_we) begin
            if (int'(bus.mem_addr) != w || bus.mem_wdata != 0) ruim++;
            w++;
         end
      end while (!pronto && n < 200);
      verifica("limpa_latencia", n, 65);
      verifica("limpa_escritas", w, 64);
      verifica("limpa_enderecos", ruim, 0);
      verifica("limpa_conflito", int'(conflito), 0);
      @(posedge clk); #1;
      verifica("limpa_valida_perdida", int'(ocupado), 0);
      valida = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 64; i++) ref_b[i] = '0;
`else
      ruim = 0;
`endif

      for (int i = 0; i < 128; i++)
         verifica($sformatf("celula_%0d", i), int'(board[i]), int'(ref_b[i]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
